alu_mdu: RTL and testbench

Parametrised successor to the single-cycle ALU decoder. It merges funct/aluop decoding with a registered ALU and an iterative multiply/divide unit that writes HI/LO registers. Sits in the execute stage of the multicycle MIPS datapath. It accepts one operation per valid/ready handshake and returns a one-cycle result pulse.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_mdu_if.sv | 31 +++
 rtl/mdu_iter.sv | 131 +++++++++++++
 rtl/alu_mdu.sv | 169 ++++++++++++++++
 tb/tb_alu_mdu.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and opcode constants for the execute-stage ALU / multiply-divide unit.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_OR    = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_e;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle between the execute-stage controller and alu_mdu.
interface alu_mdu_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             valid_i;
    logic             ready_o;
    logic [1:0]       aluop;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result_o;
    logic             result_valid_o;
    logic             zero_o;
    logic             illegal_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output valid_i, aluop, funct, a, b, shamt,
        input  ready_o, result_o, result_valid_o, zero_o, illegal_o, hi_o, lo_o
    );

    modport slave (
        input  valid_i, aluop, funct, a, b, shamt,
        output ready_o, result_o, result_valid_o, zero_o, illegal_o, hi_o, lo_o
    );

endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider with sign fix-up.
// done, hi and lo are combinational: they present the result of the final
// iteration during the cycle in which that iteration is about to be committed.
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic             neg_a_q;
    logic             neg_res_q;
    logic             div0_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] x_q;   // upper product half / partial remainder
    logic [WIDTH-1:0] y_q;   // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0] m_q;   // multiplicand / divisor magnitude

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] x_n;
    logic [WIDTH-1:0] y_n;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // Operand magnitudes for signed operations
    always_comb begin
        sign_a = is_signed & a[WIDTH-1];
        sign_b = is_signed & b[WIDTH-1];
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
    end

    // One iteration step of either the multiplier or the divider
    always_comb begin
        sum     = {1'b0, x_q} + (y_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        shifted = {x_q, y_q[WIDTH-1]};
        fits    = shifted >= {1'b0, m_q};
        x_n     = x_q;
        y_n     = y_q;
        if (div_q) begin
            if (fits) begin
                x_n = WIDTH'(shifted - {1'b0, m_q});
                y_n = {y_q[WIDTH-2:0], 1'b1};
            end else begin
                x_n = shifted[WIDTH-1:0];
                y_n = {y_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            x_n = sum[WIDTH:1];
            y_n = {sum[0], y_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the value produced by the final step; divide-by-zero bypasses it
    always_comb begin
        prod   = {x_n, y_n};
        prod_s = neg_res_q ? -prod : prod;
        quo_s  = neg_res_q ? -y_n : y_n;
        rem_s  = neg_a_q ? -x_n : x_n;
        done   = busy_q && (cnt_q == '0);
        if (div_q) begin
            if (div0_q) begin
                hi = a_q;
                lo = '1;
            end else begin
                hi = rem_s;
                lo = quo_s;
            end
        end else begin
            hi = prod_s[2*WIDTH-1:WIDTH];
            lo = prod_s[WIDTH-1:0];
        end
    end

    // Iteration state: load on start, step while busy, stop after the step at count 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_res_q <= 1'b0;
            div0_q    <= 1'b0;
            a_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            m_q       <= '0;
        end else if (start) begin
            busy_q    <= 1'b1;
            cnt_q     <= CW'(WIDTH - 1);
            div_q     <= is_div;
            neg_a_q   <= sign_a;
            neg_res_q <= sign_a ^ sign_b;
            div0_q    <= is_div && (b == '0);
            a_q       <= a;
            x_q       <= '0;
            y_q       <= is_div ? mag_a : mag_b;
            m_q       <= is_div ? mag_b : mag_a;
        end else if (busy_q) begin
            x_q   <= x_n;
            y_q   <= y_n;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: funct/aluop decode, registered single-cycle ALU,
// handshake control and HI/LO registers fed by the iterative MDU.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       reset_n,
    alu_mdu_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_MUL  = 2'(MUL);
    localparam logic [1:0] ST_DIV  = 2'(DIV);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             ready_q;
    logic             ready_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             result_valid_q;
    logic             result_valid_d;
    logic             zero_q;
    logic             zero_d;
    logic             illegal_q;
    logic             illegal_d;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] lo_d;

    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             mdu_op;
    logic             mdu_div;
    logic             mdu_signed;
    logic             start;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_hi;
    logic [WIDTH-1:0] mdu_lo;

    assign accept = bus.valid_i && ready_q;

    // Operation decode and single-cycle ALU
    always_comb begin
        alu_res    = '0;
        alu_ill    = 1'b0;
        mdu_op     = 1'b0;
        mdu_div    = 1'b0;
        mdu_signed = 1'b0;
        case (aluop_e'(bus.aluop))
            ALU_ADD: alu_res = bus.a + bus.b;
            ALU_SUB: alu_res = bus.a - bus.b;
            ALU_OR:  alu_res = bus.a | bus.b;
            ALU_FUNCT: begin
                case (bus.funct)
                    F_ADD:   alu_res = bus.a + bus.b;
                    F_SUB:   alu_res = bus.a - bus.b;
                    F_AND:   alu_res = bus.a & bus.b;
                    F_OR:    alu_res = bus.a | bus.b;
                    F_XOR:   alu_res = bus.a ^ bus.b;
                    F_NOR:   alu_res = ~(bus.a | bus.b);
                    F_SLT:   alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
                    F_SLTU:  alu_res = WIDTH'(bus.a < bus.b);
                    F_SLL:   alu_res = bus.b << bus.shamt;
                    F_SRL:   alu_res = bus.b >> bus.shamt;
                    F_SRA:   alu_res = WIDTH'($signed(bus.b) >>> bus.shamt);
                    F_MFHI:  alu_res = hi_q;
                    F_MFLO:  alu_res = lo_q;
                    F_MULT:  begin mdu_op = 1'b1; mdu_signed = 1'b1; end
                    F_MULTU: begin mdu_op = 1'b1; end
                    F_DIV:   begin mdu_op = 1'b1; mdu_div = 1'b1; mdu_signed = 1'b1; end
                    F_DIVU:  begin mdu_op = 1'b1; mdu_div = 1'b1; end
                    default: alu_ill = 1'b1;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu_iter (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .is_div   (mdu_div),
        .is_signed(mdu_signed),
        .a        (bus.a),
        .b        (bus.b),
        .done     (mdu_done),
        .hi       (mdu_hi),
        .lo       (mdu_lo)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        start          = 1'b0;
        result_valid_d = 1'b0;
        result_d       = result_q;
        zero_d         = zero_q;
        illegal_d      = illegal_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (mdu_op) begin
                        start   = 1'b1;
                        state_d = mdu_div ? ST_DIV : ST_MUL;
                    end else begin
                        result_d       = alu_res;
                        zero_d         = (alu_res == '0);
                        illegal_d      = alu_ill;
                        result_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (mdu_done) begin
                    hi_d           = mdu_hi;
                    lo_d           = mdu_lo;
                    result_d       = mdu_lo;
                    zero_d         = (mdu_lo == '0);
                    illegal_d      = 1'b0;
                    result_valid_d = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            ready_q        <= 1'b1;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            zero_q         <= 1'b1;
            illegal_q      <= 1'b0;
            hi_q           <= '0;
            lo_q           <= '0;
        end else begin
            state_q        <= state_d;
            ready_q        <= ready_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            zero_q         <= zero_d;
            illegal_q      <= illegal_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
        end
    end

    assign bus.ready_o        = ready_q;
    assign bus.result_o       = result_q;
    assign bus.result_valid_o = result_valid_q;
    assign bus.zero_o         = zero_q;
    assign bus.illegal_o      = illegal_q;
    assign bus.hi_o           = hi_q;
    assign bus.lo_o           = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (WIDTH = 32).
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    alu_mdu_if #(.WIDTH(W)) bus ();

    alu_mdu #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   aluop;
        logic [5:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   shamt;
        logic [W-1:0] res;
        logic         zero;
        logic         ill;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [1:0] op, input logic [5:0] f,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [4:0] sh, input logic [W-1:0] res,
                                input logic ill);
        vec_t v;
        v.aluop = op;  v.funct = f;  v.a = a;  v.b = b;  v.shamt = sh;
        v.res   = res; v.zero = (res == '0); v.ill = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one single-cycle op; valid_i is left high so successive calls are back-to-back
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.aluop   = v.aluop;
        bus.funct   = v.funct;
        bus.a       = v.a;
        bus.b       = v.b;
        bus.shamt   = v.shamt;
        check({tag, " ready"}, 64'(bus.ready_o), 64'(1));
        @(posedge clk); #1;
        check({tag, " valid"},   64'(bus.result_valid_o), 64'(1));
        check({tag, " result"},  64'(bus.result_o),       64'(v.res));
        check({tag, " zero"},    64'(bus.zero_o),         64'(v.zero));
        check({tag, " illegal"}, 64'(bus.illegal_o),      64'(v.ill));
    endtask

    // Issue a multi-cycle op and follow it to its completion pulse
    task automatic run_mdu(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                           input bit hold, input string tag);
        logic [W-1:0] hi0;
        logic [W-1:0] lo0;
        int lat;
        int busy_bad;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.aluop   = 2'b10;
        bus.funct   = f;
        bus.a       = a;
        bus.b       = b;
        bus.shamt   = '0;
        hi0 = bus.hi_o;
        lo0 = bus.lo_o;
        @(posedge clk); #1;
        check({tag, " ready low"}, 64'(bus.ready_o), 64'(0));
        if (hold) bus.funct = F_ADD;
        else      bus.valid_i = 1'b0;
        lat = 0;
        busy_bad = 0;
        for (int n = 1; n <= int'(W) + 4 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (bus.result_valid_o === 1'b1) lat = n;
            else if (bus.ready_o !== 1'b0 || bus.hi_o !== hi0 || bus.lo_o !== lo0) busy_bad++;
        end
        bus.valid_i = 1'b0;
        check({tag, " latency"},   64'(lat),               64'(W));
        check({tag, " busy hold"}, 64'(busy_bad),          64'(0));
        check({tag, " ready"},     64'(bus.ready_o),       64'(1));
        check({tag, " hi"},        64'(bus.hi_o),          64'(exp_hi));
        check({tag, " lo"},        64'(bus.lo_o),          64'(exp_lo));
        check({tag, " result"},    64'(bus.result_o),      64'(exp_lo));
        check({tag, " zero"},      64'(bus.zero_o),        64'(exp_lo == '0));
        check({tag, " illegal"},   64'(bus.illegal_o),     64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        checks = 0;
        errors = 0;

        vecs[0]  = mk(2'b10, F_SLT,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0);
        vecs[1]  = mk(2'b10, F_SLTU, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b0);
        vecs[2]  = mk(2'b00, 6'b111111, 32'h7,     32'h5,        5'd0,  32'hC,        1'b0);
        vecs[3]  = mk(2'b01, F_ADD,  32'h5,        32'h7,        5'd0,  32'hFFFFFFFE, 1'b0);
        vecs[4]  = mk(2'b11, F_SUB,  32'hF0,       32'h0F,       5'd0,  32'hFF,       1'b0);
        vecs[5]  = mk(2'b10, F_ADD,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b0);
        vecs[6]  = mk(2'b10, F_SUB,  32'h0,        32'h1,        5'd0,  32'hFFFFFFFF, 1'b0);
        vecs[7]  = mk(2'b10, F_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0);
        vecs[8]  = mk(2'b10, F_OR,   32'h12340000, 32'h00005678, 5'd0,  32'h12345678, 1'b0);
        vecs[9]  = mk(2'b10, F_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 5'd0,  32'hF0F00F0F, 1'b0);
        vecs[10] = mk(2'b10, F_NOR,  32'hF0F0F0F0, 32'h0F0F0000, 5'd0,  32'h00000F0F, 1'b0);
        vecs[11] = mk(2'b10, F_SLL,  32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0);
        vecs[12] = mk(2'b10, F_SRL,  32'h0,        32'h80000000, 5'd4,  32'h08000000, 1'b0);
        vecs[13] = mk(2'b10, F_SRA,  32'h0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0);
        vecs[14] = mk(2'b10, F_SLTU, 32'h1,        32'hFFFFFFFF, 5'd0,  32'h1,        1'b0);
        vecs[15] = mk(2'b10, F_SLT,  32'h5,        32'h3,        5'd0,  32'h0,        1'b0);
        vecs[16] = mk(2'b10, F_MFHI, 32'h1,        32'h2,        5'd0,  32'h0,        1'b0);
        vecs[17] = mk(2'b10, F_MFLO, 32'h1,        32'h2,        5'd0,  32'h0,        1'b0);
        vecs[18] = mk(2'b10, 6'b111111, 32'h3,     32'h4,        5'd0,  32'h0,        1'b1);
        vecs[19] = mk(2'b10, F_SRA,  32'h0,        32'h40000000, 5'd2,  32'h10000000, 1'b0);

        bus.valid_i = 1'b0;
        bus.aluop   = 2'b00;
        bus.funct   = '0;
        bus.a       = '0;
        bus.b       = '0;
        bus.shamt   = '0;
        reset_n     = 1'b1;
        #3 reset_n  = 1'b0;
        #1;
        check("reset ready",   64'(bus.ready_o),        64'(1));
        check("reset valid",   64'(bus.result_valid_o), 64'(0));
        check("reset result",  64'(bus.result_o),       64'(0));
        check("reset zero",    64'(bus.zero_o),         64'(1));
        check("reset illegal", 64'(bus.illegal_o),      64'(0));
        check("reset hi",      64'(bus.hi_o),           64'(0));
        check("reset lo",      64'(bus.lo_o),           64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end
        bus.valid_i = 1'b0;

        run_mdu(F_MULT, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, "mult -3*5");
        apply(mk(2'b10, F_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0), "mfhi after mult");
        apply(mk(2'b10, F_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFFFFF1, 1'b0), "mflo after mult");
        apply(mk(2'b10, 6'b111111, 32'h5, 32'h6, 5'd0, 32'h0, 1'b1), "illegal after mult");
        bus.valid_i = 1'b0;
        check("illegal keeps hi", 64'(bus.hi_o), 64'(32'hFFFFFFFF));
        check("illegal keeps lo", 64'(bus.lo_o), 64'(32'hFFFFFFF1));

        run_mdu(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu max");
        run_mdu(F_MULT,  32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        1'b0, "mult -1*0");
        run_mdu(F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "divu 100/7");
        run_mdu(F_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div -7/2");
        run_mdu(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, "div min/-1");
        run_mdu(F_DIVU,  32'h9,        32'h0,        32'h9,        32'hFFFFFFFF, 1'b1, "divu 9/0 held");
        pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.result_valid_o === 1'b1) pulses++;
        end
        check("held valid not queued", 64'(pulses), 64'(0));
        run_mdu(F_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, "div -7/0");
        run_mdu(F_DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0, "div 7/-2");

        // Reset in the middle of a multiply
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.aluop   = 2'b10;
        bus.funct   = F_MULT;
        bus.a       = 32'h3;
        bus.b       = 32'h5;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset ready",  64'(bus.ready_o),        64'(1));
        check("midreset hi",     64'(bus.hi_o),           64'(0));
        check("midreset lo",     64'(bus.lo_o),           64'(0));
        check("midreset valid",  64'(bus.result_valid_o), 64'(0));
        check("midreset result", 64'(bus.result_o),       64'(0));
        check("midreset zero",   64'(bus.zero_o),         64'(1));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (2 * W) begin
            @(posedge clk); #1;
            if (bus.result_valid_o === 1'b1) pulses++;
        end
        check("midreset no pulse", 64'(pulses),    64'(0));
        check("midreset hi after", 64'(bus.hi_o),  64'(0));
        check("midreset lo after", 64'(bus.lo_o),  64'(0));
        apply(mk(2'b00, F_ADD, 32'h10, 32'h20, 5'd0, 32'h30, 1'b0), "add after reset");
        bus.valid_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
